display_scan_ctrl_ca: RTL and testbench
=======================================

DISPLAY_SCAN_CTRL_CA -- requirements
Module: display_scan_ctrl_ca

Interface
REQ-001 Parameter DIV, default 50000: clocks per digit slot; legal range 4..2^20.
REQ-002 Parameter GUARD, default 500: anode-off clocks at the start of each slot; legal range 1..DIV-2.
REQ-003 clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  reset; synchronous and active-low.
REQ-005 enable  in  1  1 = scanning runs; 0 = display dark, counters held.
REQ-006 load_valid  in  1  new display image offered.
REQ-007 load_ready  out  1  pending buffer empty; image accepted on load_valid&&load_ready.
REQ-008 hex_in  in  16  four nibbles; digit0 = [3:0] ... digit3 = [15:12].
REQ-009 dp_in  in  4  decimal point per digit; 1 = lit.
REQ-010 blank_in  in  4  per-digit blank; 1 = digit dark.
REQ-011 Segments  out  7  gfedcba; active low; standard hex glyphs 0-9, A, b, C, d, E, F.
REQ-012 dp  out  1  decimal point; active low.
REQ-013 SEL  out  4  common-anode digit selects; active low; one-hot-low or all high.
REQ-014 frame_tick  out  1  one-clock pulse at each frame boundary.

Function
REQ-015 Prescaler cnt SHALL count 0..DIV-1 and wrap to 0; slot_end = (cnt==DIV-1).
REQ-016 The FSM SHALL have two states: GUARD and DRIVE.
  - GUARD -> DRIVE when cnt==GUARD-1.
  - DRIVE -> GUARD at slot_end, with digit index idx incremented mod 4 (3 -> 0 wraps).
REQ-017 In GUARD: SEL=4'b1111, Segments=7'b1111111, dp=1.
REQ-018 In DRIVE with blank[idx]=1: SEL[idx]=0 (other bits 1), Segments=7'b1111111, dp=1.
REQ-019 In DRIVE with blank[idx]=0: SEL[idx]=0 (other bits 1), Segments=glyph(active nibble idx), dp=~dp[idx].
REQ-020 Segments, dp and SEL SHALL be registered: one clock of latency after the state/idx change that selects them.
REQ-021 Frame boundary = slot_end with idx==3; frame_tick SHALL be 1 on the clock following the boundary.
REQ-022 Handshake and shadow buffer:
  - An accepted load SHALL write hex/dp/blank into the pending register and set pending_full.
  - load_ready = ~pending_full.
  - At a frame boundary with pending_full=1, pending SHALL copy into the active register and pending_full SHALL clear.
  - Active data therefore changes only between frames; no torn frames.
REQ-023 A load accepted in the same clock as a frame boundary (pending empty) SHALL be applied at the next boundary, not the current one.
REQ-024 load_valid with load_ready=0 SHALL be ignored; it is not queued.
REQ-025 enable=0:
  - cnt, idx and state SHALL hold.
  - Outputs SHALL be dark per REQ-017.
  - Loads SHALL still be accepted.
  - frame_tick SHALL be 0.
REQ-026 enable rising SHALL resume from the held cnt/idx/state; no glitch on SEL beyond REQ-020 latency.

Reset
REQ-027 While rst_n=0 at a clock edge:
  - cnt=0, idx=0, state=GUARD.
  - Segments=7'b1111111, dp=1, SEL=4'b1111, frame_tick=0.
  - pending_full=0 (load_ready=1).
  - Active hex=16'h0000, active dp=4'b0000, active blank=4'b1111.
REQ-028 Reset asserted mid-slot or mid-frame SHALL discard pending data; the display stays dark until the first load reaches the active register.

Structure
REQ-029 The shared package SHALL hold:
  - the FSM state enum;
  - the glyph constants (16 x 7-bit, active low);
  - BLANK_SEG = 7'b1111111.
REQ-030 One sub-module, hex7seg_ca_dec: combinational nibble -> active-low gfedcba glyph; instantiated once on the active nibble at idx.
REQ-031 All other logic SHALL reside in display_scan_ctrl_ca; target 150-300 lines.

Verification (DIV=8, GUARD=2)
REQ-032 Reset, then load hex=16'h1234, dp=4'b0000, blank=4'b0000:
  - first frame dark;
  - following frame drives SEL 1110/1101/1011/0111 with Segments 0011001/0110000/0100100/1111001;
  - SEL=1111 for 2 clocks per slot.
REQ-033 Back-to-back loads 16'hAAAA then 16'hBBBB: second load_valid sees load_ready=0 until the boundary; display never mixes A and b within one frame.
REQ-034 Load with blank=4'b0101, dp=4'b0010: digits 0 and 2 give SEL low with Segments=1111111; digit 1 gives dp=0.
REQ-035 enable=0 for 20 clocks mid-DRIVE of digit 2: SEL=1111 throughout; after re-enable, digit 2 completes its remaining clocks; frame_tick spacing = 32 enabled clocks.
REQ-036 Load accepted exactly on the boundary clock: applied one frame later.
REQ-037 rst_n=0 mid-frame with pending_full=1: outputs dark; load_ready=1 on the next clock.

Source files
------------

// File: rtl/display_scan_ctrl_ca_pkg.sv
// Shared types and constants for the common-anode 4-digit scan controller.
// Glyphs are gfedcba, active low (0 = segment lit).
package display_scan_ctrl_ca_pkg;

  typedef enum logic {
    ST_GUARD = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_e;

  // One complete display image: four nibbles, decimal points, blanking.
  typedef struct packed {
    logic [15:0] hex;
    logic [3:0]  dp;
    logic [3:0]  blank;
  } image_t;

  localparam logic [6:0] BLANK_SEG = 7'b1111111;

  localparam logic [6:0] GLYPH [16] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    7'b0001000,  // A
    7'b0000011,  // b
    7'b1000110,  // C
    7'b0100001,  // d
    7'b0000110,  // E
    7'b0001110   // F
  };

  function automatic logic [6:0] glyph_of(input logic [3:0] nibble);
    return GLYPH[nibble];
  endfunction

endpackage

// File: rtl/hex7seg_ca_dec.sv
// Combinational nibble to active-low gfedcba glyph decoder.
module hex7seg_ca_dec
  import display_scan_ctrl_ca_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = glyph_of(nibble);
  end

endmodule

// File: rtl/display_scan_ctrl_ca.sv
// Time-multiplexed 4-digit common-anode scan controller with a guard
// interval per slot and a frame-synchronous shadow image buffer.
module display_scan_ctrl_ca
  import display_scan_ctrl_ca_pkg::*;
#(
  parameter int unsigned DIV   = 50000,
  parameter int unsigned GUARD = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] hex_in,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blank_in,
  output logic [6:0]  Segments,
  output logic        dp,
  output logic [3:0]  SEL,
  output logic        frame_tick
);

  localparam int unsigned     CNT_W      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  scan_state_e      state_q, state_d;

  image_t pending_q, pending_d;
  logic   pending_full_q, pending_full_d;
  image_t active_q, active_d;

  logic [6:0] seg_q, seg_d;
  logic       dp_q, dp_d;
  logic [3:0] sel_q, sel_d;
  logic       frame_tick_q, frame_tick_d;

  logic       slot_end;
  logic       frame_end;
  logic       load_fire;
  logic [3:0] active_nibble;
  logic [6:0] active_glyph;

  assign slot_end  = (cnt_q == CNT_LAST);
  assign frame_end = enable && slot_end && (idx_q == 2'd3);
  assign load_fire = load_valid && !pending_full_q;

  assign active_nibble = active_q.hex[{idx_q, 2'b00} +: 4];

  hex7seg_ca_dec u_dec (
    .nibble (active_nibble),
    .seg_n  (active_glyph)
  );

  // Scan sequencing: everything freezes while enable is low.
  always_comb begin
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    state_d = state_q;
    if (enable) begin
      cnt_d = slot_end ? '0 : cnt_q + CNT_W'(1);
      unique case (state_q)
        ST_GUARD: begin
          if (cnt_q == GUARD_LAST) begin
            state_d = ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (slot_end) begin
            state_d = ST_GUARD;
            idx_d   = idx_q + 2'd1;
          end
        end
        default: state_d = ST_GUARD;
      endcase
    end
  end

  // A load taken on the boundary clock lands in pending (which was empty)
  // and therefore waits for the following boundary.
  always_comb begin
    pending_d      = pending_q;
    pending_full_d = pending_full_q;
    active_d       = active_q;
    if (load_fire) begin
      pending_d.hex   = hex_in;
      pending_d.dp    = dp_in;
      pending_d.blank = blank_in;
      pending_full_d  = 1'b1;
    end else if (frame_end && pending_full_q) begin
      active_d       = pending_q;
      pending_full_d = 1'b0;
    end
  end

  // Output image for the current slot, registered one clock later.
  always_comb begin
    seg_d        = BLANK_SEG;
    dp_d         = 1'b1;
    sel_d        = 4'b1111;
    frame_tick_d = frame_end;
    if (enable && (state_q == ST_DRIVE)) begin
      sel_d = ~(4'b0001 << idx_q);
      if (!active_q.blank[idx_q]) begin
        seg_d = active_glyph;
        dp_d  = ~active_q.dp[idx_q];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q           <= '0;
      idx_q           <= 2'd0;
      state_q         <= ST_GUARD;
      pending_q       <= '0;
      pending_full_q  <= 1'b0;
      active_q.hex    <= 16'h0000;
      active_q.dp     <= 4'b0000;
      active_q.blank  <= 4'b1111;
      seg_q           <= BLANK_SEG;
      dp_q            <= 1'b1;
      sel_q           <= 4'b1111;
      frame_tick_q    <= 1'b0;
    end else begin
      cnt_q           <= cnt_d;
      idx_q           <= idx_d;
      state_q         <= state_d;
      pending_q       <= pending_d;
      pending_full_q  <= pending_full_d;
      active_q        <= active_d;
      seg_q           <= seg_d;
      dp_q            <= dp_d;
      sel_q           <= sel_d;
      frame_tick_q    <= frame_tick_d;
    end
  end

  assign load_ready = ~pending_full_q;
  assign Segments   = seg_q;
  assign dp         = dp_q;
  assign SEL        = sel_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_display_scan_ctrl_ca.sv
// Scoreboard bench for display_scan_ctrl_ca with DIV=8, GUARD=2.
module tb_display_scan_ctrl_ca;

  localparam int DIV   = 8;
  localparam int GUARD = 2;
  localparam int FRAME = 4 * DIV;
  localparam int DRIVE = DIV - GUARD;

  localparam logic [6:0] REF_GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  localparam logic [3:0] SEL_OF [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [15:0] hex_in = 16'h0000;
  logic [3:0]  dp_in = 4'h0;
  logic [3:0]  blank_in = 4'h0;
  logic [6:0]  Segments;
  logic        dp;
  logic [3:0]  SEL;
  logic        frame_tick;

  always #5 clk = ~clk;

  display_scan_ctrl_ca #(.DIV(DIV), .GUARD(GUARD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .hex_in     (hex_in),
    .dp_in      (dp_in),
    .blank_in   (blank_in),
    .Segments   (Segments),
    .dp         (dp),
    .SEL        (SEL),
    .frame_tick (frame_tick)
  );

  typedef struct packed {
    logic [3:0] sel;
    logic [6:0] seg;
    logic       dp;
    logic       ft;
    logic       rdy;
  } exp_t;

  exp_t exp_q [$];
  exp_t cur;
  int   checks = 0;
  int   failures = 0;

  // Reference: position within the frame counted in enabled clocks.
  int          m_pos;
  logic [15:0] m_hex, p_hex;
  logic [3:0]  m_dp, p_dp, m_blank, p_blank;
  logic        m_full;

  function automatic exp_t model_out();
    exp_t e;
    int   slot;
    int   off;
    logic bnd;
    logic acc;
    e.sel = 4'hF;
    e.seg = 7'h7F;
    e.dp  = 1'b1;
    e.ft  = 1'b0;
    e.rdy = 1'b1;
    if (rst_n) begin
      slot = m_pos / DIV;
      off  = m_pos % DIV;
      bnd  = enable && (m_pos == FRAME - 1);
      acc  = load_valid && !m_full;
      if (enable && off >= GUARD) begin
        e.sel = SEL_OF[slot];
        if (!m_blank[slot]) begin
          e.seg = REF_GLYPH[m_hex[slot*4 +: 4]];
          e.dp  = ~m_dp[slot];
        end
      end
      e.ft  = bnd;
      e.rdy = !(acc || (m_full && !bnd));
    end
    return e;
  endfunction

  always @(posedge clk) begin
    exp_q.push_back(model_out());
    if (!rst_n) begin
      m_pos   <= 0;
      m_hex   <= 16'h0000;
      m_dp    <= 4'h0;
      m_blank <= 4'hF;
      m_full  <= 1'b0;
    end else begin
      if (load_valid && !m_full) begin
        p_hex   <= hex_in;
        p_dp    <= dp_in;
        p_blank <= blank_in;
        m_full  <= 1'b1;
      end else if (enable && m_pos == FRAME - 1 && m_full) begin
        m_hex   <= p_hex;
        m_dp    <= p_dp;
        m_blank <= p_blank;
        m_full  <= 1'b0;
      end
      if (enable) m_pos <= (m_pos + 1) % FRAME;
    end
  end

  task automatic step();
    @(negedge clk);
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_underflow got=empty exp=entry");
      cur = '1;
    end else begin
      cur = exp_q.pop_front();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    enable = 1'b1;
    load_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      checks++;
      if ({SEL, Segments, dp, frame_tick, load_ready} !== cur) begin
        failures++;
        $display("FAIL reset_sb i=%0d got=%b exp=%b", i, {SEL, Segments, dp, frame_tick, load_ready}, cur);
      end
      checks++;
      if ({SEL, Segments, dp, frame_tick, load_ready} !== {4'hF, 7'h7F, 1'b1, 1'b0, 1'b1}) begin
        failures++;
        $display("FAIL reset_state i=%0d got=%b exp=%b", i, {SEL, Segments, dp, frame_tick, load_ready}, {4'hF, 7'h7F, 3'b101});
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_digits();
    logic [6:0] seen [4];
    int         guard_cnt;
    bit         dark0;
    logic [6:0] want [4];
    want[0] = 7'b0011001; want[1] = 7'b0110000; want[2] = 7'b0100100; want[3] = 7'b1111001;
    for (int d = 0; d < 4; d++) seen[d] = 'x;
    guard_cnt = 0;
    dark0 = 1'b1;
    hex_in = 16'h1234; dp_in = 4'h0; blank_in = 4'h0; load_valid = 1'b1;
    for (int i = 1; i <= 2 * FRAME; i++) begin
      step();
      load_valid = 1'b0;
      checks++;
      if ({SEL, Segments, dp, frame_tick, load_ready} !== cur) begin
        failures++;
        $display("FAIL digits_sb i=%0d got=%b exp=%b", i, {SEL, Segments, dp, frame_tick, load_ready}, cur);
      end
      if (i <= FRAME && Segments !== 7'h7F) dark0 = 1'b0;
      if (i > FRAME) begin
        if (SEL === 4'hF) guard_cnt++;
        for (int d = 0; d < 4; d++) if (SEL === SEL_OF[d]) seen[d] = Segments;
      end
    end
    checks++;
    if (dark0 !== 1'b1) begin
      failures++;
      $display("FAIL digits_first_frame_dark got=%b exp=1", dark0);
    end
    checks++;
    if (guard_cnt != 4 * GUARD) begin
      failures++;
      $display("FAIL digits_guard_clocks got=%0d exp=%0d", guard_cnt, 4 * GUARD);
    end
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (seen[d] !== want[d]) begin
        failures++;
        $display("FAIL digits_glyph d=%0d got=%b exp=%b", d, seen[d], want[d]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int ready_step;
    int a_cnt [4];
    int b_cnt [4];
    int f;
    ready_step = 0;
    for (int k = 0; k < 4; k++) begin a_cnt[k] = 0; b_cnt[k] = 0; end
    hex_in = 16'hAAAA; dp_in = 4'h0; blank_in = 4'h0; load_valid = 1'b1;
    for (int i = 1; i <= 4 * FRAME; i++) begin
      step();
      checks++;
      if ({SEL, Segments, dp, frame_tick, load_ready} !== cur) begin
        failures++;
        $display("FAIL b2b_sb i=%0d got=%b exp=%b", i, {SEL, Segments, dp, frame_tick, load_ready}, cur);
      end
      if (i == 1) hex_in = 16'hBBBB;
      else if (ready_step == 0 && load_ready === 1'b1) ready_step = i;
      if (ready_step != 0 && i > ready_step) load_valid = 1'b0;
      f = (i - 1) / FRAME;
      if (SEL !== 4'hF && Segments === 7'h08) a_cnt[f]++;
      if (SEL !== 4'hF && Segments === 7'h03) b_cnt[f]++;
    end
    load_valid = 1'b0;
    checks++;
    if (ready_step != FRAME) begin
      failures++;
      $display("FAIL b2b_ready_step got=%0d exp=%0d", ready_step, FRAME);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (a_cnt[k] > 0 && b_cnt[k] > 0) begin
        failures++;
        $display("FAIL b2b_torn_frame f=%0d got=A%0d/b%0d exp=one_glyph", k, a_cnt[k], b_cnt[k]);
      end
    end
    checks++;
    if (a_cnt[1] != 4 * DRIVE || b_cnt[2] != 4 * DRIVE) begin
      failures++;
      $display("FAIL b2b_frames got=A%0d/b%0d exp=%0d", a_cnt[1], b_cnt[2], 4 * DRIVE);
    end
  endtask

  task automatic test_blank_dp();
    logic [6:0] sseg [4];
    logic       sdp [4];
    for (int d = 0; d < 4; d++) begin sseg[d] = 'x; sdp[d] = 1'bx; end
    hex_in = 16'h5678; dp_in = 4'b0010; blank_in = 4'b0101; load_valid = 1'b1;
    for (int i = 1; i <= 2 * FRAME; i++) begin
      step();
      load_valid = 1'b0;
      checks++;
      if ({SEL, Segments, dp, frame_tick, load_ready} !== cur) begin
        failures++;
        $display("FAIL blank_sb i=%0d got=%b exp=%b", i, {SEL, Segments, dp, frame_tick, load_ready}, cur);
      end
      if (i > FRAME)
        for (int d = 0; d < 4; d++) if (SEL === SEL_OF[d]) begin sseg[d] = Segments; sdp[d] = dp; end
    end
    checks++;
    if ({sseg[0], sdp[0], sseg[2], sdp[2]} !== {7'h7F, 1'b1, 7'h7F, 1'b1}) begin
      failures++;
      $display("FAIL blank_digits02 got=%b exp=%b", {sseg[0], sdp[0], sseg[2], sdp[2]}, {7'h7F, 1'b1, 7'h7F, 1'b1});
    end
    checks++;
    if ({sseg[1], sdp[1]} !== {7'h78, 1'b0}) begin
      failures++;
      $display("FAIL blank_digit1_dp got=%b exp=%b", {sseg[1], sdp[1]}, {7'h78, 1'b0});
    end
    checks++;
    if ({sseg[3], sdp[3]} !== {7'h12, 1'b1}) begin
      failures++;
      $display("FAIL blank_digit3 got=%b exp=%b", {sseg[3], sdp[3]}, {7'h12, 1'b1});
    end
  endtask

  task automatic test_enable();
    int t1;
    int t2;
    int d2_cnt;
    t1 = 0; t2 = 0; d2_cnt = 0;
    for (int i = 1; i <= 200 && t2 == 0; i++) begin
      step();
      checks++;
      if ({SEL, Segments, dp, frame_tick, load_ready} !== cur) begin
        failures++;
        $display("FAIL enable_sb i=%0d got=%b exp=%b", i, {SEL, Segments, dp, frame_tick, load_ready}, cur);
      end
      if (i > 20 && i <= 40) begin
        checks++;
        if ({SEL, frame_tick} !== {4'hF, 1'b0}) begin
          failures++;
          $display("FAIL enable_dark i=%0d got=%b exp=%b", i, {SEL, frame_tick}, {4'hF, 1'b0});
        end
      end
      if (i <= FRAME + 20 && SEL === 4'hB) d2_cnt++;
      if (frame_tick === 1'b1) begin
        if (t1 == 0) t1 = i;
        else t2 = i;
      end
      if (i == 20) enable = 1'b0;
      if (i == 40) enable = 1'b1;
    end
    enable = 1'b1;
    checks++;
    if (t1 != FRAME + 20 || t2 - t1 != FRAME) begin
      failures++;
      $display("FAIL enable_tick_spacing got=%0d,%0d exp=%0d,%0d", t1, t2 - t1, FRAME + 20, FRAME);
    end
    checks++;
    if (d2_cnt != DRIVE) begin
      failures++;
      $display("FAIL enable_digit2_clocks got=%0d exp=%0d", d2_cnt, DRIVE);
    end
  endtask

  task automatic test_boundary_load();
    int early;
    int late;
    early = 0; late = 0;
    hex_in = 16'hCDEF; dp_in = 4'h0; blank_in = 4'h0; load_valid = 1'b0;
    for (int i = 1; i <= 3 * FRAME; i++) begin
      step();
      checks++;
      if ({SEL, Segments, dp, frame_tick, load_ready} !== cur) begin
        failures++;
        $display("FAIL bnd_sb i=%0d got=%b exp=%b", i, {SEL, Segments, dp, frame_tick, load_ready}, cur);
      end
      if (i == FRAME - 1) begin
        checks++;
        if (load_ready !== 1'b1) begin
          failures++;
          $display("FAIL bnd_ready_before got=%b exp=1", load_ready);
        end
      end
      if (i == FRAME) begin
        checks++;
        if ({frame_tick, load_ready} !== 2'b10) begin
          failures++;
          $display("FAIL bnd_accept got=%b exp=10", {frame_tick, load_ready});
        end
      end
      load_valid = (i == FRAME - 1);
      if (SEL === 4'hE && Segments === 7'h0E) begin
        if (i > FRAME && i <= 2 * FRAME) early++;
        else if (i > 2 * FRAME) late++;
      end
    end
    load_valid = 1'b0;
    checks++;
    if (early != 0 || late != DRIVE) begin
      failures++;
      $display("FAIL bnd_applied_next_frame got=%0d/%0d exp=0/%0d", early, late, DRIVE);
    end
  endtask

  task automatic test_reset_mid();
    bit dark;
    dark = 1'b1;
    hex_in = 16'h1111; dp_in = 4'h0; blank_in = 4'h0; load_valid = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      load_valid = 1'b0;
      checks++;
      if ({SEL, Segments, dp, frame_tick, load_ready} !== cur) begin
        failures++;
        $display("FAIL rstmid_sb i=%0d got=%b exp=%b", i, {SEL, Segments, dp, frame_tick, load_ready}, cur);
      end
    end
    checks++;
    if (load_ready !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_pending got=%b exp=0", load_ready);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if ({SEL, Segments, dp, frame_tick, load_ready} !== {4'hF, 7'h7F, 1'b1, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL rstmid_state got=%b exp=%b", {SEL, Segments, dp, frame_tick, load_ready}, {4'hF, 7'h7F, 3'b101});
    end
    for (int i = 1; i <= 2 * FRAME; i++) begin
      step();
      checks++;
      if ({SEL, Segments, dp, frame_tick, load_ready} !== cur) begin
        failures++;
        $display("FAIL rstmid_after_sb i=%0d got=%b exp=%b", i, {SEL, Segments, dp, frame_tick, load_ready}, cur);
      end
      if (Segments !== 7'h7F || dp !== 1'b1) dark = 1'b0;
    end
    checks++;
    if (dark !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_stays_dark got=%b exp=1", dark);
    end
  endtask

  initial begin
    test_reset();
    test_digits();
    test_back_to_back();
    test_blank_dp();
    test_enable();
    test_boundary_load();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
